pwm_meas_multi: RTL and testbench
=================================

// Module: pwm_meas_multi
// PURPOSE
//  Multi-channel PWM analyser: measures high time (duty) and full period of CH independent PWM inputs,
//  in clk cycles. Each measurement is published with a one-cycle valid strobe. Dead or stuck inputs
//  are flagged. Sits between the PWM/motor-drive outputs and the telemetry/regfile layer.
// PARAMETERS
//  CH          4   number of PWM channels (1..16)
//  W           10  counter/result width per channel; max count 2^W-1
//  SYNC_STAGES 2   input synchroniser flops per channel (>=2)
// PORTS
//  clk     in   1     system clock; all logic on rising edge
//  rst     in   1     reset; synchronous, active-high
//  clr     in   1     sync soft clear: every channel to IDLE, outputs as reset
//  PWM     in   CH    asynchronous PWM inputs, bit i = channel i
//  duty    out  CH*W  channel i high-cycle count at [i*W +: W]
//  period  out  CH*W  channel i rise-to-rise cycle count at [i*W +: W]
//  vld     out  CH    1-cycle strobe: duty/period of channel i updated this cycle
//  stale   out  CH    channel i: no rising edge for 2^W-1 cycles
//  level   out  CH    synchronised (filtered) PWM level, for stuck-high/low diagnosis
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. rst, then clr: duty=0, period=0, vld=0,
//    stale=0, counters=0, state=IDLE, sync flops=0. rst/clr mid-period discards the partial measurement.
//  - Per channel: SYNC_STAGES-flop synchroniser -> p_s; p_d = p_s delayed 1 cycle; rise = p_s & ~p_d.
//  - Counters per_cnt, hi_cnt (W bits, saturating at 2^W-1, never wrap):
//    on rise both load 1 (the rising cycle counts as high); else per_cnt+1 each cycle, hi_cnt+1 while p_s=1.
//  - States per channel:
//    IDLE : wait for first rise. rise -> MEAS. No vld (no complete period yet).
//    MEAS : on rise: duty<=hi_cnt, period<=per_cnt, vld=1 next cycle, stay MEAS.
//           per_cnt reaching 2^W-1 without rise -> STALE.
//    STALE: stale=1, duty/period hold last values. rise -> MEAS, stale cleared the same cycle as
//           the counter reload, no vld (period incomplete).
//  - Latency: vld asserts SYNC_STAGES+1 cycles after the first clk edge sampling PWM high.
//  - Invariant: published duty <= period. 100% duty is reported as stale=1 with level=1.
//  - A rise coinciding with saturation: the rise wins; publish period=2^W-1, stay MEAS.
//  - Channels are fully independent; simultaneous vld on several channels is legal.
//  - duty/period registers change only on vld, rst or clr.
// CONFIGURATION
//  PWM_DEGLITCH_EN defined:
//    after the synchroniser, a 3-tap majority filter per channel; pulses of 1 cycle are suppressed.
//    Adds 2 cycles latency: vld at SYNC_STAGES+3. level is the filtered value.
//  PWM_DEGLITCH_EN undefined:
//    no filter; every synchronised edge counts, including 1-cycle pulses.
// TESTING
//  1. CH=4, W=10, PWM[0] 3 high / 7 low repeating -> first vld at 2nd rise; duty=3, period=10 each period.
//  2. Ch0 30/100 and ch2 75/100, same phase -> vld[0], vld[2] same cycle; 30/100 and 75/100; others stay 0.
//  3. PWM[1] held low 1100 cycles after 2 valid periods of 10 -> stale[1]=1 at count 1023, values held,
//     level[1]=0. Next rise: stale clears, no vld. Following rise: vld.
//  4. 4-high/6-low stream, rst asserted mid-high for 1 cycle -> outputs 0; first post-reset rise gives
//     no vld; next gives duty=4, period=10.
//  5. Without PWM_DEGLITCH_EN, a 1-cycle glitch inside the low phase -> period split (e.g. 6 and 4).
//     With it: glitch ignored, period=10; latency +2 cycles.
//  6. PWM[3] constant high from reset -> no vld; stale[3]=1 after 1023 cycles post-rise; level[3]=1.

Source files
------------

// File: rtl/pwm_meas_multi.sv
// rtl/pwm_meas_multi.sv - multi-channel PWM duty/period analyser with stale detection
// Optional 3-tap majority deglitch filter enabled by defining PWM_DEGLITCH_EN.
module pwm_meas_multi #(
    parameter int CH          = 4,
    parameter int W           = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [CH-1:0]     PWM,
    output logic [CH*W-1:0]   duty,
    output logic [CH*W-1:0]   period,
    output logic [CH-1:0]     vld,
    output logic [CH-1:0]     stale,
    output logic [CH-1:0]     level
);

    typedef enum logic [1:0] {ST_IDLE, ST_MEAS, ST_STALE} state_e;

    localparam logic [W-1:0] CNT_MAX = '1;

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q, sync_d;
        logic                   p_s, p_d_q, p_d_d, rise;
        state_e                 state_q, state_d;
        logic [W-1:0]           per_q, per_d, hi_q, hi_d;
        logic [W-1:0]           duty_q, duty_d, period_q, period_d;
        logic                   vld_q, vld_d;

        always_comb begin
            sync_d = {sync_q[SYNC_STAGES-2:0], PWM[i]};
        end

`ifdef PWM_DEGLITCH_EN
        // Majority of the current and two previous synchronised samples, then registered:
        // single-cycle pulses never win the vote.
        logic [1:0] tap_q, tap_d;
        logic       filt_q, filt_d, raw;

        always_comb begin
            raw    = sync_q[SYNC_STAGES-1];
            tap_d  = {tap_q[0], raw};
            filt_d = (raw & tap_q[0]) | (raw & tap_q[1]) | (tap_q[0] & tap_q[1]);
        end

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                tap_q  <= '0;
                filt_q <= 1'b0;
            end else begin
                tap_q  <= tap_d;
                filt_q <= filt_d;
            end
        end

        assign p_s = filt_q;
`else
        assign p_s = sync_q[SYNC_STAGES-1];
`endif

        always_comb begin
            p_d_d    = p_s;
            rise     = p_s & ~p_d_q;
            state_d  = state_q;
            duty_d   = duty_q;
            period_d = period_q;
            vld_d    = 1'b0;

            // The rising cycle itself is the first high cycle of the new period.
            if (rise) begin
                per_d = W'(1);
                hi_d  = W'(1);
            end else begin
                per_d = (per_q == CNT_MAX) ? per_q : per_q + W'(1);
                hi_d  = (p_s && hi_q != CNT_MAX) ? hi_q + W'(1) : hi_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (rise) state_d = ST_MEAS;
                end
                ST_MEAS: begin
                    if (rise) begin
                        duty_d   = hi_q;
                        period_d = per_q;
                        vld_d    = 1'b1;
                    end else if (per_q == CNT_MAX) begin
                        state_d = ST_STALE;
                    end
                end
                ST_STALE: begin
                    if (rise) state_d = ST_MEAS;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (rst || clr) begin
                sync_q   <= '0;
                p_d_q    <= 1'b0;
                state_q  <= ST_IDLE;
                per_q    <= '0;
                hi_q     <= '0;
                duty_q   <= '0;
                period_q <= '0;
                vld_q    <= 1'b0;
            end else begin
                sync_q   <= sync_d;
                p_d_q    <= p_d_d;
                state_q  <= state_d;
                per_q    <= per_d;
                hi_q     <= hi_d;
                duty_q   <= duty_d;
                period_q <= period_d;
                vld_q    <= vld_d;
            end
        end

        assign duty[i*W +: W]   = duty_q;
        assign period[i*W +: W] = period_q;
        assign vld[i]           = vld_q;
        assign stale[i]         = (state_q == ST_STALE);
        assign level[i]         = p_s;
    end

endmodule

// File: tb/tb_pwm_meas_multi.sv
// tb/tb_pwm_meas_multi.sv - directed self-checking bench for pwm_meas_multi
module tb_pwm_meas_multi;
    localparam int CH = 4;
    localparam int W  = 10;
    localparam int SS = 2;
`ifdef PWM_DEGLITCH_EN
    localparam int LAT = SS + 3;
`else
    localparam int LAT = SS + 1;
`endif

    logic              clk = 1'b0;
    logic              rst, clr;
    logic [CH-1:0]     pwm;
    logic [CH*W-1:0]   duty, period;
    logic [CH-1:0]     vld, stale, level;

    always #5 clk = ~clk;

    pwm_meas_multi #(.CH(CH), .W(W), .SYNC_STAGES(SS)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .PWM    (pwm),
        .duty   (duty),
        .period (period),
        .vld    (vld),
        .stale  (stale),
        .level  (level)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc;
    int mode[CH], hl[CH], pl[CH], ph[CH], gp[CH];
    int vcnt[CH], vcyc[CH], fv[CH], ld[CH], lp[CH];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int dch(input int i);
        return int'(duty[i*W +: W]);
    endfunction

    function automatic int pch(input int i);
        return int'(period[i*W +: W]);
    endfunction

    // One clock: drive the waveforms just after the edge, observe at the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < CH; i++) begin
            case (mode[i])
                0:       pwm[i] = 1'b0;
                1:       pwm[i] = 1'b1;
                default: begin
                    pwm[i] = (ph[i] < hl[i]) || (ph[i] == gp[i]);
                    ph[i]  = (ph[i] + 1) % pl[i];
                end
            endcase
        end
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            if (vld[i]) begin
                if (vcnt[i] == 0) fv[i] = cyc;
                vcnt[i]++;
                vcyc[i] = cyc;
                ld[i]   = dch(i);
                lp[i]   = pch(i);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clear_rec();
        for (int i = 0; i < CH; i++) begin
            vcnt[i] = 0; vcyc[i] = 0; fv[i] = 0; ld[i] = 0; lp[i] = 0;
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < CH; i++) begin
            mode[i] = 0; pl[i] = 1; ph[i] = 0; hl[i] = 0; gp[i] = -1;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        cyc = 0;
        clear_rec();
    endtask

    task automatic set_pat(input int ch, input int h, input int p, input int g);
        mode[ch] = 2; hl[ch] = h; pl[ch] = p; ph[ch] = 0; gp[ch] = g;
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        pwm = '0;
        do_reset();

        chk("rst_duty_nz",   int'(duty != '0),   0);
        chk("rst_period_nz", int'(period != '0), 0);
        chk("rst_vld",       int'(vld),          0);
        chk("rst_stale",     int'(stale),        0);
        chk("rst_level",     int'(level),        0);

        // 3 high / 7 low on channel 0
        set_pat(0, 3, 10, -1);
        run(60);
        chk("t1_first_vld_cyc", fv[0],   11 + LAT);
        chk("t1_vld_count",     vcnt[0], 5);
        chk("t1_duty",          ld[0],   3);
        chk("t1_period",        lp[0],   10);

        // two channels in phase
        do_reset();
        set_pat(0, 30, 100, -1);
        set_pat(2, 75, 100, -1);
        run(320);
        chk("t2_vcnt0",   vcnt[0], 3);
        chk("t2_vcnt2",   vcnt[2], 3);
        chk("t2_vcyc0",   vcyc[0], 301 + LAT);
        chk("t2_vcyc2",   vcyc[2], 301 + LAT);
        chk("t2_duty0",   ld[0],   30);
        chk("t2_period0", lp[0],   100);
        chk("t2_duty2",   ld[2],   75);
        chk("t2_period2", lp[2],   100);
        chk("t2_vcnt1",   vcnt[1], 0);
        chk("t2_vcnt3",   vcnt[3], 0);
        chk("t2_duty1",   dch(1),  0);
        chk("t2_period3", pch(3),  0);

        // channel 1 goes stale, then recovers
        do_reset();
        set_pat(1, 3, 10, -1);
        run(25);
        chk("t3_vcnt_pre", vcnt[1], 2);
        mode[1] = 0;
        run(1100);
        chk("t3_stale",       int'(stale[1]), 1);
        chk("t3_level",       int'(level[1]), 0);
        chk("t3_duty_hold",   dch(1),         3);
        chk("t3_period_hold", pch(1),         10);
        chk("t3_vcnt_hold",   vcnt[1],        2);
        set_pat(1, 3, 10, -1);
        run(LAT + 1);
        chk("t3_stale_clr",   int'(stale[1]), 0);
        chk("t3_no_vld",      vcnt[1],        2);
        run(16);
        chk("t3_vcnt_post",   vcnt[1],        3);
        chk("t3_duty_post",   dch(1),         3);
        chk("t3_period_post", pch(1),         10);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t3_clr_duty",   dch(1),         0);
        chk("t3_clr_period", pch(1),         0);
        chk("t3_clr_stale",  int'(stale),    0);

        // reset pulse during the high phase of a 4/10 stream
        do_reset();
        set_pat(0, 4, 10, -1);
        run(24);
        chk("t4_pre_duty", dch(0), 4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t4_rst_duty",   dch(0),    0);
        chk("t4_rst_period", pch(0),    0);
        chk("t4_rst_vld",    int'(vld), 0);
        vcnt[0] = 0;
        run(15);
        chk("t4_first_rise_novld", vcnt[0], 0);
        run(10);
        chk("t4_vcnt",   vcnt[0], 1);
        chk("t4_duty",   ld[0],   4);
        chk("t4_period", lp[0],   10);

        // single-cycle glitch in the low phase
        do_reset();
        set_pat(0, 3, 10, 6);
        run(24);
`ifdef PWM_DEGLITCH_EN
        chk("t5_vcyc",    vcyc[0], 16);
        chk("t5_duty_a",  ld[0],   3);
        chk("t5_period_a", lp[0],  10);
        run(6);
        chk("t5_duty_b",  ld[0],   3);
        chk("t5_period_b", lp[0],  10);
`else
        chk("t5_vcyc",    vcyc[0], 24);
        chk("t5_duty_a",  ld[0],   1);
        chk("t5_period_a", lp[0],  4);
        run(6);
        chk("t5_duty_b",  ld[0],   3);
        chk("t5_period_b", lp[0],  6);
`endif

        // channel 3 held high
        do_reset();
        mode[3] = 1;
        run(1015);
        chk("t6_not_yet_stale", int'(stale[3]), 0);
        run(20);
        chk("t6_stale", int'(stale[3]), 1);
        chk("t6_level", int'(level[3]), 1);
        chk("t6_vcnt",  vcnt[3],        0);

        // period exactly at the saturation count: rise wins
        do_reset();
        set_pat(2, 5, 1023, -1);
        run(2055);
        chk("t7_vcnt",   vcnt[2],        2);
        chk("t7_period", lp[2],          1023);
        chk("t7_duty",   ld[2],          5);
        chk("t7_stale",  int'(stale[2]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
